input_stream_mem: RTL and testbench
===================================

INPUT_STREAM_MEM -- requirements
Module: input_stream_mem

Interface
REQ-001 SHALL take parameter: MEM_WORDS, 1024, depth of the 32-bit frame buffer; word index is paddr[11:2].
REQ-002 SHALL take parameter: LEN_W, 13, width of the byte-length register; maximum 4096 bytes = 4*MEM_WORDS.
REQ-003 SHALL use one clock and a synchronous, active-high reset; both are listed below.
REQ-004 S_APB_aclk  in  1  sole clock; all logic on its rising edge.
REQ-005 S_APB_areset  in  1  synchronous active-high reset.
REQ-006 S_APB_paddr  in  32  APB address.
REQ-007 S_APB_psel, S_APB_penable, S_APB_pwrite  in  1 each  APB controls.
REQ-008 S_APB_pwdata  in  32  APB write data.
REQ-009 S_APB_prdata  out  32  APB read data, registered.
REQ-010 S_APB_pready  out  1  APB ready.
REQ-011 S_APB_pslverr  out  1  tied 0.
REQ-012 M_AXIS_tdata  out  8  stream byte.
REQ-013 M_AXIS_tvalid, M_AXIS_tkeep, M_AXIS_tlast  out  1 each  stream qualifiers; tkeep tied 1.
REQ-014 M_AXIS_tready  in  1  downstream ready.

Function
REQ-015 Address map SHALL be: paddr[12]=0 selects frame buffer word paddr[11:2]; 0x1000 CTRL (W: bit0 START, self-clearing, reads 0); 0x1004 LEN (R/W, bits[LEN_W-1:0]); 0x1008 STATUS (RO: bit0 BUSY, bit1 DONE).
REQ-016 pready SHALL be registered: pready <= psel & penable & !pready, giving one wait state and a one-cycle pulse per access.
REQ-017 Writes SHALL commit on the cycle where psel & penable & pready & pwrite; reads SHALL present data on prdata in the same pready cycle.
REQ-018 The frame buffer SHALL be inferred as block RAM with one APB write port and one synchronous read port; APB reads and stream fetch SHALL share that read port via a mux, with the stream fetch taking priority when BUSY.
REQ-019 APB frame-buffer reads while BUSY SHALL return 0; APB frame-buffer writes while BUSY SHALL be accepted, and a word already fetched SHALL NOT change.
REQ-020 FSM states SHALL be IDLE, PRIME, STREAM.
REQ-021 IDLE -> PRIME on START with LEN != 0: clear DONE, set BUSY, issue read of word 0.
REQ-022 START with LEN == 0 SHALL set DONE, leave BUSY at 0 and emit no beats.
REQ-023 PRIME -> STREAM after exactly one cycle: load word 0 into cur_word, assert tvalid, and issue prefetch read of word 1.
REQ-024 In STREAM, tdata SHALL be cur_word[8*b+7:8*b] with byte order b = 0,1,2,3, i.e. byte 0 is word bits[7:0].
REQ-025 A beat SHALL complete on tvalid & tready; b and byte_cnt SHALL advance only on a completed beat.
REQ-026 On a completed beat with b == 3, cur_word SHALL load the prefetched word, and the read of the following word SHALL issue in the same cycle.
REQ-027 tvalid SHALL stay high from the first beat through the last beat of a frame with no bubbles while tready is high; the downstream capture counter restarts on any tvalid gap.
REQ-028 While tready is low, tdata, tlast and tvalid SHALL hold stable.
REQ-029 tlast SHALL be 1 only on the beat where byte_cnt == LEN-1.
REQ-030 A completed tlast beat SHALL return the FSM to IDLE, drive tvalid 0 the next cycle, clear BUSY and set DONE.
REQ-031 If LEN is not a multiple of 4, unused upper bytes of the final word SHALL NOT be emitted.
REQ-032 START and LEN writes while BUSY SHALL be ignored.
REQ-033 Word addressing SHALL NOT wrap; LEN values above 4*MEM_WORDS SHALL saturate to 4*MEM_WORDS.

Reset
REQ-034 On reset, the block SHALL set: FSM IDLE, tvalid 0, tlast 0, tdata 0, pready 0, prdata 0, LEN 0, BUSY 0, DONE 0.
REQ-035 The frame buffer contents SHALL NOT be reset.
REQ-036 Reset asserted mid-frame SHALL drop tvalid the following cycle, with no tlast emitted.

Verification
REQ-037 Write words 0x44332211 and 0x88776655 to 0x000 and 0x004, LEN=8, START, tready=1 -> tdata 11,22,...,88 on 8 consecutive cycles; tlast only on 0x88; STATUS=0x2 afterwards.
REQ-038 LEN=6 with the same data -> 6 beats 11..66, tlast on 0x66.
REQ-039 LEN=4096 with tready=1 -> 4096 gapless beats with tvalid never low mid-frame; a paired downstream capture memory matches all 1024 words.
REQ-040 tready toggled 1/0 every cycle -> tdata and tlast held stable during stalls; byte sequence unchanged.
REQ-041 LEN=0 then START -> no tvalid, DONE=1, BUSY=0; a second START or a LEN write while BUSY -> ignored.
REQ-042 Reset asserted at beat 5 of an 8-byte frame -> tvalid 0 the next cycle, STATUS=0, memory word 0 reads back 0x44332211.

Source files
------------

// File: rtl/input_stream_mem_if.sv
// Bus bundle for input_stream_mem: APB register/frame-buffer port plus the AXI-Stream byte output.
// The slave modport is the block's view; the master modport is the view of whatever drives the APB
// side and sinks the stream.
interface input_stream_mem_if;
  logic [31:0] s_apb_paddr;
  logic        s_apb_psel;
  logic        s_apb_penable;
  logic        s_apb_pwrite;
  logic [31:0] s_apb_pwdata;
  logic [31:0] s_apb_prdata;
  logic        s_apb_pready;
  logic        s_apb_pslverr;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  modport slave (
    input  s_apb_paddr, s_apb_psel, s_apb_penable, s_apb_pwrite, s_apb_pwdata, m_axis_tready,
    output s_apb_prdata, s_apb_pready, s_apb_pslverr,
    output m_axis_tdata, m_axis_tvalid, m_axis_tkeep, m_axis_tlast
  );

  modport master (
    output s_apb_paddr, s_apb_psel, s_apb_penable, s_apb_pwrite, s_apb_pwdata, m_axis_tready,
    input  s_apb_prdata, s_apb_pready, s_apb_pslverr,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tkeep, m_axis_tlast
  );
endinterface

// File: rtl/input_stream_mem.sv
// APB-loaded frame buffer that replays LEN bytes as a gapless AXI-Stream byte frame on START.
// One block RAM: APB write port, one synchronous read port shared between APB reads and the
// stream fetch (fetch owns it while busy).
module input_stream_mem #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LEN_W     = 13
) (
  input logic               S_APB_aclk,
  input logic               S_APB_areset,
  input_stream_mem_if.slave bus
);
  localparam int unsigned      AW       = $clog2(MEM_WORDS);
  localparam logic [LEN_W-1:0] LenMax   = LEN_W'(4 * MEM_WORDS);
  localparam logic [AW:0]      WordsEnd = (AW+1)'(MEM_WORDS);

  typedef enum logic [1:0] {StIdle, StPrime, StStream} state_e;

  state_e           state_q, state_d;
  logic             pready_q, pready_d;
  logic [31:0]      prdata_q, prdata_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic [31:0]      cur_word_q, cur_word_d;
  logic [1:0]       b_q, b_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [AW:0]      fetch_q, fetch_d;  // index of the word held in ram_rdata_q
  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;

  logic [31:0]      mem [MEM_WORDS];
  logic [31:0]      ram_rdata_q;
  logic             ram_en;
  logic [AW-1:0]    ram_addr;

  logic             busy, in_window, mem_sel, ctrl_hit, len_hit, stat_hit;
  logic             acc_phase, wr_commit, start_go, beat;
  logic [AW-1:0]    apb_idx;
  logic [LEN_W-1:0] wr_len;

  assign busy      = (state_q != StIdle);
  assign in_window = (bus.s_apb_paddr[31:13] == '0);
  assign mem_sel   = in_window & ~bus.s_apb_paddr[12];
  assign ctrl_hit  = in_window & (bus.s_apb_paddr[12:0] == 13'h1000);
  assign len_hit   = in_window & (bus.s_apb_paddr[12:0] == 13'h1004);
  assign stat_hit  = in_window & (bus.s_apb_paddr[12:0] == 13'h1008);
  assign apb_idx   = bus.s_apb_paddr[AW+1:2];
  assign acc_phase = bus.s_apb_psel & bus.s_apb_penable & ~pready_q;
  assign wr_commit = bus.s_apb_psel & bus.s_apb_penable & pready_q & bus.s_apb_pwrite;
  assign start_go  = wr_commit & ctrl_hit & bus.s_apb_pwdata[0] & ~busy;
  assign beat      = tvalid_q & bus.m_axis_tready;
  assign wr_len    = (bus.s_apb_pwdata[LEN_W-1:0] > LenMax) ? LenMax : bus.s_apb_pwdata[LEN_W-1:0];

  // APB write port; busy-time writes reach RAM but never the held cur_word/prefetch registers
  always_ff @(posedge S_APB_aclk) begin
    if (wr_commit && mem_sel) mem[apb_idx] <= bus.s_apb_pwdata;
  end

  // Shared synchronous read port; only re-read on enable so a prefetched word stays put
  always_ff @(posedge S_APB_aclk) begin
    if (ram_en) ram_rdata_q <= mem[ram_addr];
  end

  // Next-state for APB handshake, registers, FSM and stream outputs
  always_comb begin
    state_d    = state_q;
    pready_d   = bus.s_apb_psel & bus.s_apb_penable & ~pready_q;
    prdata_d   = prdata_q;
    len_d      = len_q;
    done_d     = done_q;
    cur_word_d = cur_word_q;
    b_d        = b_q;
    byte_cnt_d = byte_cnt_q;
    fetch_d    = fetch_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    ram_en     = 1'b0;
    ram_addr   = apb_idx;

    // ram_rdata_q was addressed during the setup cycle, so it is valid in the access cycle
    if (acc_phase && !bus.s_apb_pwrite) begin
      prdata_d = '0;
      if (mem_sel && !busy) prdata_d = ram_rdata_q;
      else if (len_hit)     prdata_d = {{(32-LEN_W){1'b0}}, len_q};
      else if (stat_hit)    prdata_d = {30'b0, done_q, busy};
    end

    unique case (state_q)
      StIdle: begin
        ram_en = 1'b1;
        if (wr_commit && len_hit) len_d = wr_len;
        if (start_go) begin
          if (len_q == '0) begin
            done_d = 1'b1;
          end else begin
            done_d   = 1'b0;
            state_d  = StPrime;
            ram_addr = '0;
            fetch_d  = '0;
          end
        end
      end
      StPrime: begin
        cur_word_d = ram_rdata_q;
        tdata_d    = ram_rdata_q[7:0];
        tvalid_d   = 1'b1;
        tlast_d    = (len_q == LEN_W'(1));
        b_d        = '0;
        byte_cnt_d = '0;
        state_d    = StStream;
        fetch_d    = (AW+1)'(1);
        if (fetch_d < WordsEnd) begin
          ram_en   = 1'b1;
          ram_addr = fetch_d[AW-1:0];
        end
      end
      StStream: begin
        if (beat) begin
          if (tlast_q) begin
            state_d  = StIdle;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            done_d   = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            b_d        = b_q + 2'd1;
            tlast_d    = (byte_cnt_d == len_q - 1'b1);
            if (b_q == 2'd3) begin
              cur_word_d = ram_rdata_q;
              tdata_d    = ram_rdata_q[7:0];
              fetch_d    = fetch_q + 1'b1;
              // no wrap: the read past the last word is simply not issued
              if (fetch_d < WordsEnd) begin
                ram_en   = 1'b1;
                ram_addr = fetch_d[AW-1:0];
              end
            end else begin
              tdata_d = cur_word_q[{b_d, 3'b000} +: 8];
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; frame buffer is not reset
  always_ff @(posedge S_APB_aclk) begin
    if (S_APB_areset) begin
      state_q    <= StIdle;
      pready_q   <= 1'b0;
      prdata_q   <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
      cur_word_q <= '0;
      b_q        <= '0;
      byte_cnt_q <= '0;
      fetch_q    <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pready_q   <= pready_d;
      prdata_q   <= prdata_d;
      len_q      <= len_d;
      done_q     <= done_d;
      cur_word_q <= cur_word_d;
      b_q        <= b_d;
      byte_cnt_q <= byte_cnt_d;
      fetch_q    <= fetch_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
    end
  end

  assign bus.s_apb_prdata  = prdata_q;
  assign bus.s_apb_pready  = pready_q;
  assign bus.s_apb_pslverr = 1'b0;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tkeep  = 1'b1;
  assign bus.m_axis_tlast  = tlast_q;
endmodule

// File: tb/tb_input_stream_mem.sv
// Scoreboard bench for input_stream_mem: expected {tlast,tdata} pushed at START, popped per beat.
module tb_input_stream_mem;
  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned LEN_W     = 13;

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  input_stream_mem_if bus ();

  input_stream_mem #(
    .MEM_WORDS(MEM_WORDS),
    .LEN_W    (LEN_W)
  ) dut (
    .S_APB_aclk  (clk),
    .S_APB_areset(areset),
    .bus         (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_mem [MEM_WORDS];
  logic [31:0] cap_mem [MEM_WORDS];
  logic [8:0]  sb_q [$];
  int          rdy_mode = 0;
  int          cyc = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  int          cap_idx = 0;
  int          total_beats = 0;
  logic        in_frame = 1'b0;
  logic        prev_tvalid = 1'b0;
  logic        stall_pend = 1'b0;
  logic [9:0]  stall_snap = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Downstream ready pattern: 0 = always ready, 1 = toggle every cycle
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) bus.m_axis_tready = ~bus.m_axis_tready;
    else               bus.m_axis_tready = 1'b1;
  end

  // Stream monitor: scoreboard compare, stall stability, gap detection, capture memory
  always @(negedge clk) begin
    if (areset) begin
      in_frame   = 1'b0;
      stall_pend = 1'b0;
    end else begin
      if (stall_pend)
        check_eq("stall_hold", {22'b0, bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata},
                 {22'b0, stall_snap});
      stall_pend = bus.m_axis_tvalid & ~bus.m_axis_tready;
      stall_snap = {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata};
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        check_eq("no_gap", 32'(!in_frame || prev_tvalid), 32'd1);
        if (!in_frame) begin
          first_cyc = cyc;
          cap_idx   = 0;
        end
        in_frame = 1'b1;
        if (sb_q.size() != 0)
          check_eq("beat", {23'b0, bus.m_axis_tlast, bus.m_axis_tdata}, {23'b0, sb_q.pop_front()});
        if (cap_idx < 4 * MEM_WORDS) cap_mem[cap_idx / 4][8 * (cap_idx % 4) +: 8] = bus.m_axis_tdata;
        cap_idx++;
        total_beats++;
        if (bus.m_axis_tlast) begin
          in_frame = 1'b0;
          last_cyc = cyc;
        end
      end
      prev_tvalid = bus.m_axis_tvalid;
    end
  end

  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
    int n = 0;
    @(posedge clk); #1;
    bus.s_apb_paddr   = addr;
    bus.s_apb_pwrite  = wr;
    bus.s_apb_pwdata  = wdata;
    bus.s_apb_psel    = 1'b1;
    bus.s_apb_penable = 1'b0;
    @(posedge clk); #1;
    bus.s_apb_penable = 1'b1;
    @(posedge clk); #1;
    while (!bus.s_apb_pready && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 8) check_eq("apb_pready_timeout", 32'(bus.s_apb_pready), 32'd1);
    rdata = bus.s_apb_prdata;
    @(posedge clk); #1;
    bus.s_apb_psel    = 1'b0;
    bus.s_apb_penable = 1'b0;
    bus.s_apb_pwrite  = 1'b0;
  endtask

  task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    apb_xfer(addr, 1'b1, data, dummy);
    if (addr < 32'h1000) exp_mem[addr[11:2]] = data;
  endtask

  task automatic apb_rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    apb_xfer(addr, 1'b0, 32'h0, r);
    check_eq(tag, r, exp);
  endtask

  task automatic start_frame(input int len);
    logic [31:0] w;
    for (int i = 0; i < len; i++) begin
      w = exp_mem[i / 4];
      sb_q.push_back({(i == len - 1), w[8 * (i % 4) +: 8]});
    end
    apb_wr(32'h1000, 32'h1);
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while ((sb_q.size() != 0 || bus.m_axis_tvalid) && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq(tag, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int errs;
    bus.s_apb_paddr   = '0;
    bus.s_apb_psel    = 1'b0;
    bus.s_apb_penable = 1'b0;
    bus.s_apb_pwrite  = 1'b0;
    bus.s_apb_pwdata  = '0;
    areset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check_eq("rst_tlast",  32'(bus.m_axis_tlast), 32'd0);
    check_eq("rst_tdata",  32'(bus.m_axis_tdata), 32'd0);
    check_eq("rst_pready", 32'(bus.s_apb_pready), 32'd0);
    check_eq("rst_prdata", bus.s_apb_prdata, 32'd0);
    check_eq("tkeep",      32'(bus.m_axis_tkeep), 32'd1);
    check_eq("pslverr",    32'(bus.s_apb_pslverr), 32'd0);
    areset = 1'b0;
    apb_rd_chk("rst_status", 32'h1008, 32'h0);
    apb_rd_chk("rst_len",    32'h1004, 32'h0);

    // Basic 8-byte frame
    apb_wr(32'h000, 32'h44332211);
    apb_wr(32'h004, 32'h88776655);
    apb_rd_chk("mem_rd0", 32'h000, 32'h44332211);
    apb_rd_chk("mem_rd1", 32'h004, 32'h88776655);
    apb_wr(32'h1004, 32'd8);
    apb_rd_chk("len8", 32'h1004, 32'd8);
    start_frame(8);
    wait_done("frame8_done", 100);
    check_eq("frame8_gapless", 32'(last_cyc - first_cyc), 32'd7);
    apb_rd_chk("status8", 32'h1008, 32'h2);

    // Partial final word
    apb_wr(32'h1004, 32'd6);
    start_frame(6);
    wait_done("frame6_done", 100);
    check_eq("frame6_gapless", 32'(last_cyc - first_cyc), 32'd5);
    apb_rd_chk("status6", 32'h1008, 32'h2);

    // Stalling downstream plus APB traffic while busy
    for (int i = 2; i < 10; i++) apb_wr(32'(i * 4), $urandom);
    apb_wr(32'h1004, 32'd40);
    rdy_mode = 1;
    start_frame(40);
    apb_wr(32'h004, 32'h0BADF00D);
    apb_rd_chk("status_busy", 32'h1008, 32'h1);
    apb_rd_chk("busy_mem_rd", 32'h000, 32'h0);
    apb_wr(32'h1004, 32'd3);
    apb_wr(32'h1000, 32'h1);
    apb_wr(32'h320, 32'hCAFEF00D);
    wait_done("frame40_done", 400);
    rdy_mode = 0;
    apb_rd_chk("len_kept", 32'h1004, 32'd40);
    apb_rd_chk("status40", 32'h1008, 32'h2);
    apb_rd_chk("busy_wr_mem", 32'h320, 32'hCAFEF00D);
    apb_rd_chk("busy_wr_w1", 32'h004, 32'h0BADF00D);

    // Full buffer with saturated length
    for (int i = 0; i < MEM_WORDS; i++) apb_wr(32'(i * 4), $urandom);
    apb_wr(32'h1004, 32'd5000);
    apb_rd_chk("len_sat", 32'h1004, 32'd4096);
    start_frame(4096);
    apb_rd_chk("status_busy4k", 32'h1008, 32'h1);
    wait_done("frame4k_done", 6000);
    check_eq("frame4k_gapless", 32'(last_cyc - first_cyc), 32'd4095);
    errs = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (cap_mem[i] !== exp_mem[i]) errs++;
    check_eq("cap_words", 32'(errs), 32'd0);
    apb_rd_chk("status4k", 32'h1008, 32'h2);

    // Reset in the middle of an 8-byte frame
    apb_wr(32'h000, 32'h44332211);
    apb_wr(32'h004, 32'h88776655);
    apb_wr(32'h1004, 32'd8);
    b0 = total_beats;
    start_frame(8);
    for (int n = 0; n < 100 && (total_beats - b0) < 5; n++) begin
      @(posedge clk); #1;
    end
    check_eq("rst_mid_beats", 32'(total_beats - b0), 32'd5);
    areset = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_mid_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check_eq("rst_mid_tlast",  32'(bus.m_axis_tlast), 32'd0);
    check_eq("rst_mid_left",   32'(sb_q.size()), 32'd3);
    sb_q.delete();
    @(posedge clk); #1;
    areset = 1'b0;
    apb_rd_chk("rst_mid_status", 32'h1008, 32'h0);
    apb_rd_chk("rst_mid_mem0",   32'h000, 32'h44332211);
    apb_rd_chk("rst_mid_len",    32'h1004, 32'h0);

    // Zero length START
    apb_wr(32'h1004, 32'd0);
    b0 = total_beats;
    start_frame(0);
    repeat (20) @(posedge clk);
    #1;
    check_eq("len0_no_beats", 32'(total_beats - b0), 32'd0);
    check_eq("len0_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    apb_rd_chk("len0_status", 32'h1008, 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
